// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM sequencer: FSM state encoding,
// host register addresses and the period reset value.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_PERIOD,
    ST_LOAD_DUTY,
    ST_DWELL
  } seq_state_t;

  localparam logic [3:0]  ADDR_PERIOD = 4'd8;
  localparam logic [3:0]  ADDR_DWELL  = 4'd9;
  localparam logic [3:0]  ADDR_LENGTH = 4'd10;

  localparam logic [11:0] PERIOD_RST  = 12'hFFF;

endpackage

// File: rtl/pwm_seq_table.sv
// Duty table: DEPTH x DATA_W register file, one synchronous host write port,
// one asynchronous read port; cleared by reset.
module pwm_seq_table #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pwm_sequencer.sv
// Autonomous writer for the pwm_generator port: period once, then table duties
// per dwell interval. Define PWM_SEQ_PINGPONG_EN for a 0->length->0 index sweep.
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DWELL_W = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_wr,
  input  logic [3:0]                cfg_addr,
  input  logic [DATA_W-1:0]         cfg_data,
  input  logic                      start,
  input  logic                      stop,
  output logic [DATA_W-1:0]         pwm_in,
  output logic                      pwm_sel,
  output logic                      pwm_wr_en,
  output logic                      busy,
  output logic [$clog2(DEPTH)-1:0]  idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  seq_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_adv;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   period_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [IDX_W-1:0]    len_q;
  logic [DATA_W-1:0]   tbl_rd;
  logic [DATA_W-1:0]   pwm_in_d;
  logic                pwm_sel_d, wr_en_d, busy_d;
  logic                tbl_wr;
`ifdef PWM_SEQ_PINGPONG_EN
  logic                dir_q, dir_d, dir_adv;
`endif

  assign tbl_wr = cfg_wr && (32'(cfg_addr) < DEPTH);

  pwm_seq_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tbl_wr),
    .wr_addr (cfg_addr[IDX_W-1:0]),
    .wr_data (cfg_data),
    .rd_addr (idx_q),
    .rd_data (tbl_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= DATA_W'(PERIOD_RST);
      dwell_q  <= '0;
      len_q    <= '0;
    end else if (cfg_wr) begin
      unique case (cfg_addr)
        ADDR_PERIOD: period_q <= cfg_data;
        ADDR_DWELL:  dwell_q  <= DWELL_W'(cfg_data);
        ADDR_LENGTH: len_q    <= cfg_data[IDX_W-1:0];
        default: ;
      endcase
    end
  end

  // An index beyond a freshly shortened length falls back to entry 0.
`ifdef PWM_SEQ_PINGPONG_EN
  always_comb begin
    idx_adv = '0;
    dir_adv = 1'b0;
    if (idx_q > len_q || len_q == '0) begin
      idx_adv = '0;
      dir_adv = 1'b0;
    end else if (!dir_q) begin
      if (idx_q == len_q) begin
        idx_adv = idx_q - IDX_W'(1);
        dir_adv = 1'b1;
      end else begin
        idx_adv = idx_q + IDX_W'(1);
      end
    end else begin
      if (idx_q == '0) begin
        idx_adv = IDX_W'(1);
      end else begin
        idx_adv = idx_q - IDX_W'(1);
        dir_adv = 1'b1;
      end
    end
  end
`else
  always_comb begin
    idx_adv = (idx_q >= len_q) ? '0 : idx_q + IDX_W'(1);
  end
`endif

  // Outputs are registered from the current state, so strobes trail the state by one edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pwm_in_d  = pwm_in;
    pwm_sel_d = pwm_sel;
    wr_en_d   = 1'b0;
    busy_d    = (state_q != ST_IDLE);
`ifdef PWM_SEQ_PINGPONG_EN
    dir_d     = dir_q;
`endif
    if (state_q != ST_IDLE && stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d = ST_LOAD_PERIOD;
            idx_d   = '0;
`ifdef PWM_SEQ_PINGPONG_EN
            dir_d   = 1'b0;
`endif
          end
        end
        ST_LOAD_PERIOD: begin
          pwm_in_d  = period_q;
          pwm_sel_d = 1'b0;
          wr_en_d   = 1'b1;
          state_d   = ST_LOAD_DUTY;
        end
        ST_LOAD_DUTY: begin
          pwm_in_d  = tbl_rd;
          pwm_sel_d = 1'b1;
          wr_en_d   = 1'b1;
          cnt_d     = dwell_q;
          state_d   = ST_DWELL;
        end
        ST_DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else begin
            idx_d   = idx_adv;
`ifdef PWM_SEQ_PINGPONG_EN
            dir_d   = dir_adv;
`endif
            state_d = ST_LOAD_DUTY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pwm_in    <= '0;
      pwm_sel   <= 1'b0;
      pwm_wr_en <= 1'b0;
      busy      <= 1'b0;
`ifdef PWM_SEQ_PINGPONG_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pwm_in    <= pwm_in_d;
      pwm_sel   <= pwm_sel_d;
      pwm_wr_en <= wr_en_d;
      busy      <= busy_d;
`ifdef PWM_SEQ_PINGPONG_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign idx = idx_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench for pwm_sequencer: directed steps plus randomized runs
// checked against a write-schedule model derived from the register contents.
module tb_pwm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cfg_wr;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        start;
  logic        stop;
  logic [11:0] pwm_in;
  logic        pwm_sel;
  logic        pwm_wr_en;
  logic        busy;
  logic [2:0]  idx;

  int checks = 0;
  int errors = 0;

  logic [11:0] m_tbl [8];
  logic [11:0] m_period;
  int          m_dwell;
  int          m_len;

  pwm_sequencer #(
    .DATA_W  (12),
    .DEPTH   (8),
    .DWELL_W (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .stop      (stop),
    .pwm_in    (pwm_in),
    .pwm_sel   (pwm_sel),
    .pwm_wr_en (pwm_wr_en),
    .busy      (busy),
    .idx       (idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Table index of the n-th duty write of a run.
  function automatic int seq_idx(input int n, input int len);
`ifdef PWM_SEQ_PINGPONG_EN
    int p;
    if (len == 0) return 0;
    p = n % (2 * len);
    return (p <= len) ? p : 2 * len - p;
`else
    return n % (len + 1);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = 12'h000;
    m_period = 12'hFFF;
    m_dwell  = 0;
    m_len    = 0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [11:0] d);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
    if (a < 4'd8)       m_tbl[a[2:0]] = d;
    else if (a == 4'd8) m_period = d;
    else if (a == 4'd9) m_dwell = int'(d);
    else if (a == 4'd10) m_len = int'(d[2:0]);
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_wr"}, 32'(pwm_wr_en), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
    end
  endtask

  // Start a run, follow ncyc cycles from the first duty write, then stop.
  task automatic run_check(input int ncyc, input bit mid_wr);
    logic [11:0] run_period, exp_val, last_val, nv;
    logic        last_sel;
    int          p, n, wr_at;
    run_period = m_period;
    p          = m_dwell + 2;
    wr_at      = int'($urandom_range(0, 2));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_period_wr", 32'(pwm_wr_en), 32'(0));
    chk("pre_period_busy", 32'(busy), 32'(0));
    @(negedge clk);
    chk("period_wr", 32'(pwm_wr_en), 32'(1));
    chk("period_sel", 32'(pwm_sel), 32'(0));
    chk("period_val", 32'(pwm_in), 32'(run_period));
    chk("period_busy", 32'(busy), 32'(1));
    last_val = run_period;
    last_sel = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      cfg_wr = 1'b0;
      start  = 1'($urandom_range(0, 1));
      n = t / p;
      chk("run_busy", 32'(busy), 32'(1));
      if (t % p == 0) begin
        exp_val = m_tbl[seq_idx(n, m_len)];
        chk("duty_wr", 32'(pwm_wr_en), 32'(1));
        chk("duty_sel", 32'(pwm_sel), 32'(1));
        chk("duty_val", 32'(pwm_in), 32'(exp_val));
        chk("duty_idx", 32'(idx), 32'(seq_idx(n, m_len)));
        last_val = exp_val;
        last_sel = 1'b1;
        if (mid_wr && t + 1 < ncyc) begin
          nv = 12'($urandom_range(0, 4095));
          if (n == wr_at) begin
            cfg_wr = 1'b1; cfg_addr = 4'd2; cfg_data = nv; m_tbl[2] = nv;
          end else if (n == wr_at + 1) begin
            cfg_wr = 1'b1; cfg_addr = 4'd8; cfg_data = nv; m_period = nv;
          end
        end
      end else begin
        chk("dwell_wr", 32'(pwm_wr_en), 32'(0));
      end
    end
    cfg_wr = 1'b0;
    start  = 1'b0;
    stop   = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_wr", 32'(pwm_wr_en), 32'(0));
    chk("stop_hold_val", 32'(pwm_in), 32'(last_val));
    chk("stop_hold_sel", 32'(pwm_sel), 32'(last_sel));
    idle_check(4, "after_stop");
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_wr", 32'(pwm_wr_en), 32'(0));
    chk("rst_sel", 32'(pwm_sel), 32'(0));
    chk("rst_in", 32'(pwm_in), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_idx", 32'(idx), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Unconfigured run: period FFF, zero duties every 2 cycles at idx 0.
    run_check(9, 1'b0);

    // Ramp.
    for (int i = 0; i < 4; i++) cfg_write(4'(i), 12'(100 * (i + 1)));
    cfg_write(4'd10, 12'd3);
    cfg_write(4'd9, 12'd5);
    run_check(50, 1'b0);

    // Randomized configurations with mid-run table[2] and period writes.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) cfg_write(4'(i), 12'($urandom_range(0, 4095)));
      cfg_write(4'd10, 12'($urandom_range(0, 4095)));
      cfg_write(4'd9, 12'($urandom_range(0, 6)));
      cfg_write(4'd8, 12'($urandom_range(0, 4095)));
      cfg_write(4'($urandom_range(11, 15)), 12'($urandom_range(0, 4095)));
      run_check(int'($urandom_range(8, 60)), 1'b1);
    end

    // start and stop together in IDLE: nothing happens.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    idle_check(5, "start_stop_idle");

    // Async reset while in LOAD_DUTY, right after the period strobe.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_wr", 32'(pwm_wr_en), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr", 32'(pwm_wr_en), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_in", 32'(pwm_in), 32'(0));
    chk("async_rst_idx", 32'(idx), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_check(7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
